fir_seq_ctrl: RTL and testbench
===============================

Name: fir_seq_ctrl

Overview:
Sequencer for the single-multiplier/single-adder FIR datapath.
- Runs one job from ap_start: clears data RAM, accepts samples on AXI-Stream, walks tap RAM and circular data RAM once per sample, strobes the MAC, handshakes each result out.
- Arbitrates tap RAM between the AXI-Lite config path and compute.
- Sits between the AXI-Lite register file, the stream ports and the two BRAMs; the accumulator lives outside.

Parameters:
pADDR_WIDTH, 12, BRAM byte-address width
pDATA_WIDTH, 32, sample/coefficient width
Tape_Num, 11, tap count and data-RAM depth (words)

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  reset
ap_start  in  1  one-cycle job start pulse from config regs
data_length  in  32  samples per job; 0 = end on tlast only
ap_idle  out  1  no job running
ap_done  out  1  job complete, sticky
len_err  out  1  tlast and data_length disagreed, sticky
ss_tvalid  in  1  input sample valid
ss_tdata  in  pDATA_WIDTH  input sample
ss_tlast  in  1  last input sample
ss_tready  out  1  sample accept
sm_tready  in  1  downstream ready
sm_tvalid  out  1  result valid (data from external accumulator)
sm_tlast  out  1  last result
mac_clr  out  1  load accumulator with product instead of adding
mac_en  out  1  product tap_Do*data_Do valid this cycle
cfg_tap_en  in  1  config tap RAM request
cfg_tap_we  in  4  config byte write enables
cfg_tap_a  in  pADDR_WIDTH  config byte address
cfg_tap_di  in  pDATA_WIDTH  config write data
cfg_tap_gnt  out  1  config access granted this cycle
tap_WE  out  4  tap RAM write enables
tap_EN  out  1  tap RAM enable
tap_Di  out  pDATA_WIDTH  tap RAM write data
tap_A  out  pADDR_WIDTH  tap RAM byte address
data_WE  out  4  data RAM write enables
data_EN  out  1  data RAM enable
data_Di  out  pDATA_WIDTH  data RAM write data
data_A  out  pADDR_WIDTH  data RAM byte address

Behaviour:
Reset and idle values
- Reset is axis_rst_n, asynchronous, active-low. Clock is axis_clk.
- In reset, every output is 0 except ap_idle=1.
- Reset mid-job aborts the job and returns to IDLE. Pointers and counters clear.

Addressing
- Addresses are word index × 4.
- BRAM read latency is 1 cycle.

State machine (encoded in fir_pkg)
- IDLE: ap_idle=1. ap_start → INIT. ap_start also clears ap_done and len_err.
- INIT: Tape_Num cycles. data_EN=1, data_WE=4'hF, data_Di=0, data_A=i*4 for i=0..Tape_Num-1. Then → WAIT_IN with wr_ptr=0 and cnt=0.
- WAIT_IN: ss_tready=1.
  - On handshake, in the same cycle: data_WE=4'hF, data_A=wr_ptr*4, data_Di=ss_tdata. Latch ss_tlast. → MAC with k=0.
- MAC: Tape_Num cycles, k=0..Tape_Num-1.
  - tap_EN=1, tap_A=k*4.
  - data_EN=1, data_A=((wr_ptr-k) mod Tape_Num)*4.
  - Then → DRAIN.
- MAC strobes: mac_en is a 1-cycle-delayed copy of "MAC active". mac_clr accompanies the first mac_en of each sample.
- DRAIN: 1 cycle; the final mac_en occurs here. → OUT.
- OUT: sm_tvalid=1, held until sm_tready. sm_tlast=1 if this is the job's last sample. On handshake:
  - wr_ptr advances, wrapping Tape_Num-1 → 0.
  - cnt increments.
  - If last → DONE, else → WAIT_IN.
- Last sample: latched tlast, or cnt+1==data_length when data_length≠0.
- len_err: set when tlast arrives with cnt+1≠data_length (data_length≠0), or when the count is reached without tlast. Either condition still ends the job.
- DONE: ap_done=1 and ap_idle=1, both held until the next ap_start. ap_start → INIT.

Throughput and stalls
- Minimum Tape_Num+3 cycles per sample (WAIT_IN 1 + MAC Tape_Num + DRAIN 1 + OUT 1).
- ss_tready is 0 outside WAIT_IN. sm_tvalid is 0 outside OUT.

Tap RAM arbitration
- In IDLE/DONE: cfg_tap_gnt=cfg_tap_en, and the tap_* outputs mux from the cfg_* inputs.
- In all other states: cfg_tap_gnt=0 and config requests stall.
- ap_start coinciding with cfg_tap_en: config wins that cycle, and INIT begins the next cycle.
- ap_start while busy is ignored.

Decomposition:
- fir_pkg: state encodings, WORD_BYTES=4, WE_ALL=4'hF.
- One sub-module, fir_tap_arb: combinational tap RAM mux plus grant. It must never drive a write to tap RAM while compute is active.

Test Plan:
- Reset mid-MAC (Tape_Num=11) → outputs 0 except ap_idle=1; next ap_start restarts INIT with addresses 0x00..0x28.
- ap_start, data_length=3, 3 samples with tlast on the 3rd, sm_tready=1 → 11 zero writes; each sample done in 14 cycles; sm_tlast only on the 3rd; ap_done=1; len_err=0.
- Sample #1 (wr_ptr=1) → MAC data_A sequence 0x04,0x00,0x28,0x24,…,0x08; tap_A 0x00..0x28; 11 mac_en with mac_clr on the first.
- 12 samples → the 12th write lands at data_A=0x00 (wrap); wr_ptr back to 1 afterwards.
- sm_tready low 5 cycles in OUT → sm_tvalid held; ss_tready stays 0; no extra mac_en.
- data_length=5 with tlast on sample 2 → job ends after 2 results; len_err=1.
- cfg_tap_en during MAC → cfg_tap_gnt=0; tap_WE=0.
- cfg_tap_en in DONE → cfg_tap_gnt=1; tap_A=cfg_tap_a.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared encodings and constants for the FIR sequencer.
package fir_pkg;

  // Job sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WAIT_IN = 3'd2,
    ST_MAC     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_OUT     = 3'd5,
    ST_DONE    = 3'd6
  } fir_state_t;

  // BRAM addresses are byte addresses of 32-bit words
  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] WE_ALL     = 4'hF;

endpackage

// File: rtl/fir_tap_arb.sv
// Tap RAM port mux: the config path owns the RAM while no job runs,
// otherwise compute reads it. Compute never writes tap RAM.
module fir_tap_arb #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   host_own,
  input  logic                   cfg_tap_en,
  input  logic [3:0]             cfg_tap_we,
  input  logic [pADDR_WIDTH-1:0] cfg_tap_a,
  input  logic [pDATA_WIDTH-1:0] cfg_tap_di,
  input  logic                   comp_en,
  input  logic [pADDR_WIDTH-1:0] comp_a,
  output logic                   cfg_tap_gnt,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A
);

  // Select the tap RAM master; write enables only ever come from config
  always_comb begin
    cfg_tap_gnt = 1'b0;
    tap_WE      = 4'h0;
    tap_EN      = 1'b0;
    tap_Di      = '0;
    tap_A       = '0;
    if (host_own) begin
      cfg_tap_gnt = cfg_tap_en;
      tap_EN      = cfg_tap_en;
      tap_WE      = cfg_tap_en ? cfg_tap_we : 4'h0;
      tap_Di      = cfg_tap_di;
      tap_A       = cfg_tap_a;
    end else begin
      tap_EN      = comp_en;
      tap_A       = comp_a;
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR job sequencer: clears the data RAM, takes one sample at a time,
// walks taps and the circular data window for the external MAC, and
// hands each result downstream. Also arbitrates tap RAM with config.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   len_err,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic                   mac_clr,
  output logic                   mac_en,
  input  logic                   cfg_tap_en,
  input  logic [3:0]             cfg_tap_we,
  input  logic [pADDR_WIDTH-1:0] cfg_tap_a,
  input  logic [pDATA_WIDTH-1:0] cfg_tap_di,
  output logic                   cfg_tap_gnt,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A
);

  localparam int                IDX_W    = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(Tape_Num - 1);

  fir_state_t       state_reg, state_next;
  logic [IDX_W-1:0] init_idx_reg;
  logic [IDX_W-1:0] k_reg;
  logic [IDX_W-1:0] wr_ptr_reg;
  logic [IDX_W-1:0] rd_ptr_reg;
  logic [31:0]      cnt_reg;
  logic             tlast_reg;
  logic             mac_en_reg;
  logic             mac_clr_reg;
  logic             len_err_reg;

  logic                   start_go;
  logic                   count_hit;
  logic                   is_last;
  logic                   len_mismatch;
  logic                   host_own;
  logic                   comp_en;
  logic [pADDR_WIDTH-1:0] comp_a;

  // Word index to BRAM byte address
  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] idx);
    return pADDR_WIDTH'(idx) * pADDR_WIDTH'(WORD_BYTES);
  endfunction

  assign start_go     = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && ap_start;
  assign count_hit    = (data_length != 32'd0) && ((cnt_reg + 32'd1) == data_length);
  assign is_last      = tlast_reg || count_hit;
  // tlast and the programmed count must land on the same sample
  assign len_mismatch = (data_length != 32'd0) &&
                        (tlast_reg != ((cnt_reg + 32'd1) == data_length));

  assign ap_done  = (state_reg == ST_DONE);
  assign len_err  = len_err_reg;
  assign mac_en   = mac_en_reg;
  assign mac_clr  = mac_clr_reg;
  // Config sees the tap RAM only between jobs and never while reset is held
  assign host_own = axis_rst_n && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // State register
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Pointers, counters, sample flags and the delayed MAC strobes
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      init_idx_reg <= '0;
      k_reg        <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      cnt_reg      <= '0;
      tlast_reg    <= 1'b0;
      mac_en_reg   <= 1'b0;
      mac_clr_reg  <= 1'b0;
      len_err_reg  <= 1'b0;
    end else begin
      // Product of the cycle's RAM reads appears one cycle after the read
      mac_en_reg  <= (state_reg == ST_MAC);
      mac_clr_reg <= (state_reg == ST_MAC) && (k_reg == '0);
      if (start_go) begin
        init_idx_reg <= '0;
        wr_ptr_reg   <= '0;
        cnt_reg      <= '0;
        len_err_reg  <= 1'b0;
      end
      case (state_reg)
        ST_INIT: begin
          init_idx_reg <= init_idx_reg + 1'b1;
        end
        ST_WAIT_IN: begin
          if (ss_tvalid) begin
            tlast_reg  <= ss_tlast;
            k_reg      <= '0;
            rd_ptr_reg <= wr_ptr_reg;
          end
        end
        ST_MAC: begin
          k_reg      <= k_reg + 1'b1;
          // Walk backwards through the circular window, newest sample first
          rd_ptr_reg <= (rd_ptr_reg == '0) ? LAST_IDX : rd_ptr_reg - 1'b1;
        end
        ST_OUT: begin
          if (sm_tready) begin
            wr_ptr_reg <= (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + 1'b1;
            cnt_reg    <= cnt_reg + 32'd1;
            if (is_last && len_mismatch) begin
              len_err_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and per-state RAM / stream controls
  always_comb begin
    state_next = state_reg;
    ap_idle    = 1'b0;
    ss_tready  = 1'b0;
    sm_tvalid  = 1'b0;
    sm_tlast   = 1'b0;
    data_EN    = 1'b0;
    data_WE    = 4'h0;
    data_Di    = '0;
    data_A     = '0;
    comp_en    = 1'b0;
    comp_a     = '0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_next = ST_INIT;
        end
      end
      ST_INIT: begin
        data_EN = 1'b1;
        data_WE = WE_ALL;
        data_A  = word_addr(init_idx_reg);
        if (init_idx_reg == LAST_IDX) begin
          state_next = ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN    = 1'b1;
          data_WE    = WE_ALL;
          data_A     = word_addr(wr_ptr_reg);
          data_Di    = ss_tdata;
          state_next = ST_MAC;
        end
      end
      ST_MAC: begin
        comp_en = 1'b1;
        comp_a  = word_addr(k_reg);
        data_EN = 1'b1;
        data_A  = word_addr(rd_ptr_reg);
        if (k_reg == LAST_IDX) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_next = ST_OUT;
      end
      ST_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = is_last;
        if (sm_tready) begin
          state_next = is_last ? ST_DONE : ST_WAIT_IN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  fir_tap_arb #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_tap_arb (
    .host_own   (host_own),
    .cfg_tap_en (cfg_tap_en),
    .cfg_tap_we (cfg_tap_we),
    .cfg_tap_a  (cfg_tap_a),
    .cfg_tap_di (cfg_tap_di),
    .comp_en    (comp_en),
    .comp_a     (comp_a),
    .cfg_tap_gnt(cfg_tap_gnt),
    .tap_WE     (tap_WE),
    .tap_EN     (tap_EN),
    .tap_Di     (tap_Di),
    .tap_A      (tap_A)
  );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with Tape_Num=11.
module tb_fir_seq_ctrl;

  localparam int TN = 11;

  logic        axis_clk;
  logic        axis_rst_n;
  logic        ap_start;
  logic [31:0] data_length;
  logic        ap_idle, ap_done, len_err;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tready, sm_tvalid, sm_tlast;
  logic        mac_clr, mac_en;
  logic        cfg_tap_en, cfg_tap_gnt;
  logic [3:0]  cfg_tap_we;
  logic [11:0] cfg_tap_a;
  logic [31:0] cfg_tap_di;
  logic [3:0]  tap_WE, data_WE;
  logic        tap_EN, data_EN;
  logic [31:0] tap_Di, data_Di;
  logic [11:0] tap_A, data_A;

  int n_vec  = 0;
  int n_miss = 0;

  fir_seq_ctrl dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .ap_start   (ap_start),
    .data_length(data_length),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .len_err    (len_err),
    .ss_tvalid  (ss_tvalid),
    .ss_tdata   (ss_tdata),
    .ss_tlast   (ss_tlast),
    .ss_tready  (ss_tready),
    .sm_tready  (sm_tready),
    .sm_tvalid  (sm_tvalid),
    .sm_tlast   (sm_tlast),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .cfg_tap_en (cfg_tap_en),
    .cfg_tap_we (cfg_tap_we),
    .cfg_tap_a  (cfg_tap_a),
    .cfg_tap_di (cfg_tap_di),
    .cfg_tap_gnt(cfg_tap_gnt),
    .tap_WE     (tap_WE),
    .tap_EN     (tap_EN),
    .tap_Di     (tap_Di),
    .tap_A      (tap_A),
    .data_WE    (data_WE),
    .data_EN    (data_EN),
    .data_Di    (data_Di),
    .data_A     (data_A)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge while idle/done; returns at the falling edge of WAIT_IN
  task automatic start_job(input logic [31:0] len, input bit cfg_chk);
    ap_start    = 1'b1;
    data_length = len;
    #1;
    check_vec("start_idle", 32'(ap_idle), 32'd1);
    if (cfg_chk) begin
      check_vec("start_cfg_gnt", 32'(cfg_tap_gnt), 32'd1);
      check_vec("start_cfg_we", 32'(tap_WE), 32'hF);
      check_vec("start_cfg_a", 32'(tap_A), 32'(cfg_tap_a));
    end
    @(negedge axis_clk);
    ap_start = 1'b0;
    for (int i = 0; i < TN; i++) begin
      #1;
      check_vec("init_a", 32'(data_A), 32'(i * 4));
      check_vec("init_we", 32'(data_WE), 32'hF);
      check_vec("init_en", 32'(data_EN), 32'd1);
      check_vec("init_di", data_Di, 32'd0);
      check_vec("init_gnt", 32'(cfg_tap_gnt), 32'd0);
      if (i == 0) begin
        check_vec("init_flags", 32'({ap_idle, ap_done, len_err}), 32'd0);
      end
      @(negedge axis_clk);
    end
  endtask

  // Called at the falling edge of WAIT_IN; returns one edge after the result handshake
  task automatic send_sample(input logic [31:0] d, input bit last_in, input int wr,
                             input bit exp_last, input int stall);
    ss_tvalid = 1'b1;
    ss_tdata  = d;
    ss_tlast  = last_in;
    #1;
    check_vec("in_ready", 32'(ss_tready), 32'd1);
    check_vec("in_we", 32'(data_WE), 32'hF);
    check_vec("in_a", 32'(data_A), 32'(wr * 4));
    check_vec("in_di", data_Di, d);
    @(negedge axis_clk);
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
    for (int k = 0; k < TN; k++) begin
      #1;
      check_vec("mac_tap_a", 32'(tap_A), 32'(k * 4));
      check_vec("mac_tap_en", 32'(tap_EN), 32'd1);
      check_vec("mac_data_a", 32'(data_A), 32'(((wr + TN - k) % TN) * 4));
      check_vec("mac_en", 32'(mac_en), 32'(k != 0));
      check_vec("mac_clr", 32'(mac_clr), 32'(k == 1));
      check_vec("mac_cfg", 32'({cfg_tap_gnt, tap_WE, data_WE, ss_tready}), 32'd0);
      @(negedge axis_clk);
    end
    #1;
    check_vec("drain_en", 32'({mac_en, mac_clr, sm_tvalid}), 32'b100);
    sm_tready = (stall == 0);
    @(negedge axis_clk);
    for (int s = 0; s < stall; s++) begin
      #1;
      check_vec("stall_hold", 32'({sm_tvalid, ss_tready, mac_en}), 32'b100);
      @(negedge axis_clk);
    end
    sm_tready = 1'b1;
    #1;
    check_vec("out_valid", 32'(sm_tvalid), 32'd1);
    check_vec("out_last", 32'(sm_tlast), 32'(exp_last));
    $display("sample wr_ptr=%0d data=0x%0h tlast=%0b result_last=%0b", wr, d, last_in, sm_tlast);
    @(negedge axis_clk);
  endtask

  task automatic check_done(input bit exp_err);
    #1;
    check_vec("done_flag", 32'(ap_done), 32'd1);
    check_vec("done_idle", 32'(ap_idle), 32'd1);
    check_vec("done_len_err", 32'(len_err), 32'(exp_err));
    check_vec("done_quiet", 32'({ss_tready, sm_tvalid, mac_en}), 32'd0);
  endtask

  initial begin
    axis_rst_n  = 1'b0;
    ap_start    = 1'b0;
    data_length = 32'd0;
    ss_tvalid   = 1'b0;
    ss_tdata    = 32'd0;
    ss_tlast    = 1'b0;
    sm_tready   = 1'b1;
    cfg_tap_en  = 1'b0;
    cfg_tap_we  = 4'h0;
    cfg_tap_a   = 12'h0;
    cfg_tap_di  = 32'd0;

    // Reset values
    repeat (3) @(negedge axis_clk);
    #1;
    check_vec("rst_idle", 32'(ap_idle), 32'd1);
    check_vec("rst_ctl", 32'({ap_done, len_err, ss_tready, sm_tvalid, sm_tlast, mac_clr,
                              mac_en, cfg_tap_gnt, tap_WE, tap_EN, data_WE, data_EN}), 32'd0);
    check_vec("rst_bus", 32'({|tap_Di, |tap_A, |data_Di, |data_A}), 32'd0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);

    // Reset in the middle of MAC aborts the job
    start_job(32'd3, 1'b0);
    ss_tvalid = 1'b1;
    ss_tdata  = 32'h55;
    @(negedge axis_clk);
    ss_tvalid = 1'b0;
    repeat (4) @(negedge axis_clk);
    axis_rst_n = 1'b0;
    #1;
    check_vec("midrst_idle", 32'(ap_idle), 32'd1);
    check_vec("midrst_ctl", 32'({ap_done, len_err, ss_tready, sm_tvalid, sm_tlast, mac_clr,
                                 mac_en, cfg_tap_gnt, tap_WE, tap_EN, data_WE, data_EN}), 32'd0);
    check_vec("midrst_bus", 32'({|tap_Di, |tap_A, |data_Di, |data_A}), 32'd0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);

    // Three samples, length and tlast agree
    start_job(32'd3, 1'b0);
    send_sample(32'h11, 1'b0, 0, 1'b0, 0);
    send_sample(32'h22, 1'b0, 1, 1'b0, 0);
    send_sample(32'h33, 1'b1, 2, 1'b1, 0);
    check_done(1'b0);

    // Config access while done
    cfg_tap_en = 1'b1;
    cfg_tap_we = 4'h3;
    cfg_tap_a  = 12'h014;
    cfg_tap_di = 32'hCAFE_0001;
    #1;
    check_vec("done_gnt", 32'(cfg_tap_gnt), 32'd1);
    check_vec("done_tap_a", 32'(tap_A), 32'h014);
    check_vec("done_tap_we", 32'(tap_WE), 32'h3);
    check_vec("done_tap_di", tap_Di, 32'hCAFE_0001);
    @(negedge axis_clk);

    // ap_start together with a config write; config held during the job
    cfg_tap_we = 4'hF;
    cfg_tap_a  = 12'h02C;
    start_job(32'd5, 1'b1);
    send_sample(32'hA1, 1'b0, 0, 1'b0, 0);
    send_sample(32'hA2, 1'b1, 1, 1'b1, 5);
    check_done(1'b1);
    cfg_tap_en = 1'b0;
    cfg_tap_we = 4'h0;
    @(negedge axis_clk);

    // Count reached without tlast
    start_job(32'd2, 1'b0);
    send_sample(32'hB1, 1'b0, 0, 1'b0, 0);
    send_sample(32'hB2, 1'b0, 1, 1'b1, 0);
    check_done(1'b1);
    @(negedge axis_clk);

    // tlast-only job of 13 samples: pointer wraps at the 12th
    start_job(32'd0, 1'b0);
    for (int n = 0; n < 13; n++) begin
      send_sample(32'(32'hC00 + n), (n == 12), n % TN, (n == 12), 0);
    end
    check_done(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
